imem_arbiter: RTL and testbench

- Shares one single-port, byte-lane-enabled instruction memory between two requesters: the core instruction-fetch port (read-only) and the program loader/debug port (read and write).
- Arbitrates between them, sequences the memory's fixed read latency, and returns responses over valid/ready handshakes.
- One transaction is in flight at a time.
- Sits between the fetch stage / loader and the instruction memory array.

---
 rtl/imem_pkg.sv | 25 ++
 rtl/imem_arbiter.sv | 132 +++++++++++++
 tb/tb_imem_arbiter.sv | 361 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/imem_pkg.sv
// Shared encodings for the instruction-memory arbiter: FSM states, grant owner
// and the legal memory-latency window.
package imem_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    WAIT,
    CAPT,
    RESP
  } state_t;

  typedef enum logic {
    GNT_FETCH  = 1'b0,
    GNT_LOADER = 1'b1
  } gnt_t;

  localparam int MEM_LAT_MIN = 1;
  localparam int MEM_LAT_MAX = 4;

  function automatic bit mem_lat_ok(input int lat);
    return (lat >= MEM_LAT_MIN) && (lat <= MEM_LAT_MAX);
  endfunction

endpackage

// File: rtl/imem_arbiter.sv
// Two-requester arbiter in front of a single-port instruction memory: fetch
// (read-only) and loader (read/write), one transaction in flight at a time.
module imem_arbiter
  import imem_pkg::*;
#(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int MEM_LAT = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            f_req_valid,
  output logic            f_req_ready,
  input  logic [AW-1:0]   f_req_addr,
  output logic            f_rsp_valid,
  input  logic            f_rsp_ready,
  output logic [DW-1:0]   f_rsp_data,
  output logic            f_rsp_err,
  input  logic            l_lock,
  input  logic            l_req_valid,
  output logic            l_req_ready,
  input  logic            l_req_we,
  input  logic [AW-1:0]   l_req_addr,
  input  logic [DW-1:0]   l_req_wdata,
  input  logic [DW/8-1:0] l_req_be,
  output logic            l_rsp_valid,
  input  logic            l_rsp_ready,
  output logic [DW-1:0]   l_rsp_data,
  output logic            l_rsp_err,
  output logic            m_en,
  output logic            m_we,
  output logic [AW-1:0]   m_addr,
  output logic [DW-1:0]   m_wdata,
  output logic [DW/8-1:0] m_be,
  input  logic [DW-1:0]   m_rdata,
  output logic            busy
);

  localparam logic [1:0] LAT_INIT = (MEM_LAT > 1) ? 2'(MEM_LAT - 2) : 2'd0;

  generate
    if (!mem_lat_ok(MEM_LAT) || (DW != 32)) begin : g_bad_param
      $error("imem_arbiter: MEM_LAT must be 1..4 and DW must be 32");
    end
  endgenerate

  state_t        state, state_n;
  gnt_t          last_grant, owner;
  logic [1:0]    lat_cnt;
  logic          we_q;
  logic          err_q;
  logic [DW-1:0] rsp_data;

  logic          grant_f, grant_l, acc, acc_we, acc_misal, rsp_ready;
  logic [AW-1:0] acc_addr;

  // Round-robin: on a tie the side that did not win last time goes first.
  always_comb begin
    grant_f = f_req_valid && !l_lock && (!l_req_valid || (last_grant == GNT_LOADER));
    grant_l = l_req_valid && !grant_f;
  end

  assign f_req_ready = rst_n && (state == IDLE) && grant_f;
  assign l_req_ready = rst_n && (state == IDLE) && grant_l;
  assign acc         = f_req_ready || l_req_ready;
  assign acc_addr    = grant_f ? f_req_addr : l_req_addr;
  assign acc_we      = grant_l && l_req_we;
  assign acc_misal   = (acc_addr[1:0] != 2'b00);
  assign rsp_ready   = (owner == GNT_FETCH) ? f_rsp_ready : l_rsp_ready;

  always_comb begin
    state_n = state;
    case (state)
      IDLE: if (acc) state_n = (!acc_we && acc_misal) ? RESP : CMD;
      CMD: begin
        if (we_q)              state_n = IDLE;
        else if (MEM_LAT == 1) state_n = CAPT;
        else                   state_n = WAIT;
      end
      WAIT: if (lat_cnt == 2'd0) state_n = CAPT;
      CAPT: state_n = RESP;
      RESP: if (rsp_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      last_grant <= GNT_LOADER;
      owner      <= GNT_FETCH;
      lat_cnt    <= 2'd0;
      we_q       <= 1'b0;
      err_q      <= 1'b0;
      rsp_data   <= '0;
      m_en       <= 1'b0;
      m_we       <= 1'b0;
      m_addr     <= '0;
      m_wdata    <= '0;
      m_be       <= '0;
    end else begin
      state <= state_n;
      m_en  <= (state_n == CMD);
      m_we  <= (state_n == CMD) && acc_we;
      if (acc) begin
        owner      <= grant_f ? GNT_FETCH : GNT_LOADER;
        last_grant <= grant_f ? GNT_FETCH : GNT_LOADER;
        we_q       <= acc_we;
        err_q      <= !acc_we && acc_misal;
        rsp_data   <= '0;
        // Memory-side outputs only move when an access is actually issued.
        if (state_n == CMD) begin
          m_addr <= {acc_addr[AW-1:2], 2'b00};
          m_be   <= acc_we ? l_req_be : '1;
          if (acc_we) m_wdata <= l_req_wdata;
        end
      end
      if (state == CMD)                         lat_cnt <= LAT_INIT;
      else if (state == WAIT && lat_cnt != 2'd0) lat_cnt <= lat_cnt - 2'd1;
      if (state == CAPT) rsp_data <= m_rdata;
    end
  end

  assign busy        = (state != IDLE);
  assign f_rsp_valid = (state == RESP) && (owner == GNT_FETCH);
  assign l_rsp_valid = (state == RESP) && (owner == GNT_LOADER);
  assign f_rsp_data  = rsp_data;
  assign l_rsp_data  = rsp_data;
  assign f_rsp_err   = f_rsp_valid && err_q;
  assign l_rsp_err   = l_rsp_valid && err_q;

endmodule

// File: tb/tb_imem_arbiter.sv
// Bench for imem_arbiter: a MEM_LAT=1 instance for directed, table and random
// traffic, and a MEM_LAT=3 instance for reset-during-wait and latency.
module tb_imem_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, f_req_valid, f_req_ready, f_rsp_valid, f_rsp_ready, f_rsp_err;
  logic [31:0] f_req_addr, f_rsp_data;
  logic        l_lock, l_req_valid, l_req_ready, l_req_we, l_rsp_valid, l_rsp_ready, l_rsp_err;
  logic [31:0] l_req_addr, l_req_wdata, l_rsp_data;
  logic [3:0]  l_req_be, m_be;
  logic        m_en, m_we, busy;
  logic [31:0] m_addr, m_wdata, m_rdata;

  logic        rst3_n, f_req_valid3, f_req_ready3, f_rsp_valid3, f_rsp_err3;
  logic [31:0] f_req_addr3, f_rsp_data3;
  logic        l_req_ready3, l_rsp_valid3, l_rsp_err3, m_en3, m_we3, busy3;
  logic [31:0] l_rsp_data3, m_addr3, m_wdata3, m_rdata3;
  logic [3:0]  m_be3;

  imem_arbiter #(.AW(32), .DW(32), .MEM_LAT(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .f_req_valid(f_req_valid), .f_req_ready(f_req_ready), .f_req_addr(f_req_addr),
    .f_rsp_valid(f_rsp_valid), .f_rsp_ready(f_rsp_ready), .f_rsp_data(f_rsp_data),
    .f_rsp_err(f_rsp_err), .l_lock(l_lock), .l_req_valid(l_req_valid),
    .l_req_ready(l_req_ready), .l_req_we(l_req_we), .l_req_addr(l_req_addr),
    .l_req_wdata(l_req_wdata), .l_req_be(l_req_be), .l_rsp_valid(l_rsp_valid),
    .l_rsp_ready(l_rsp_ready), .l_rsp_data(l_rsp_data), .l_rsp_err(l_rsp_err),
    .m_en(m_en), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_be(m_be),
    .m_rdata(m_rdata), .busy(busy)
  );

  imem_arbiter #(.AW(32), .DW(32), .MEM_LAT(3)) dut3 (
    .clk(clk), .rst_n(rst3_n),
    .f_req_valid(f_req_valid3), .f_req_ready(f_req_ready3), .f_req_addr(f_req_addr3),
    .f_rsp_valid(f_rsp_valid3), .f_rsp_ready(1'b1), .f_rsp_data(f_rsp_data3),
    .f_rsp_err(f_rsp_err3), .l_lock(1'b0), .l_req_valid(1'b0),
    .l_req_ready(l_req_ready3), .l_req_we(1'b0), .l_req_addr(32'h0),
    .l_req_wdata(32'h0), .l_req_be(4'h0), .l_rsp_valid(l_rsp_valid3),
    .l_rsp_ready(1'b1), .l_rsp_data(l_rsp_data3), .l_rsp_err(l_rsp_err3),
    .m_en(m_en3), .m_we(m_we3), .m_addr(m_addr3), .m_wdata(m_wdata3), .m_be(m_be3),
    .m_rdata(m_rdata3), .busy(busy3)
  );

  // Memory array behind both instances; garbage outside valid read slots.
  logic [31:0] mem [0:255];
  logic [31:0] ref_mem [0:255];
  logic        mem_init_done = 1'b0;
  logic [31:0] rd1, rd3a, rd3b, rd3c;

  function automatic logic [31:0] init_val(input int i);
    if (i == 16) return 32'h0000_0013;
    if (i == 4)  return 32'h1122_3344;
    return 32'hA500_0000 ^ (32'(i) * 32'h0103_0507);
  endfunction

  always @(posedge clk) begin
    if (!mem_init_done) begin
      for (int i = 0; i < 256; i++) mem[i] <= init_val(i);
      mem_init_done <= 1'b1;
    end else if (m_en && m_we) begin
      for (int b = 0; b < 4; b++)
        if (m_be[b]) mem[m_addr[9:2]][8*b +: 8] <= m_wdata[8*b +: 8];
    end
    rd1  <= (m_en && !m_we) ? mem[m_addr[9:2]] : 32'hBAD0_BAD0;
    rd3a <= (m_en3 && !m_we3) ? mem[m_addr3[9:2]] : 32'hBAD0_BAD0;
    rd3b <= rd3a;
    rd3c <= rd3b;
  end
  assign m_rdata  = rd1;
  assign m_rdata3 = rd3c;

  int checks = 0;
  int errors = 0;
  int last_w = 2;  // 1 = fetch won last, 2 = loader won last

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chkb(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  // Reference arbitration: fetch is eligible only unlocked; ties alternate.
  function automatic int pick(input bit fv, input bit lv, input bit lock, input int last);
    bit fe;
    fe = fv && !lock;
    if (fe && lv) return (last == 1) ? 2 : 1;
    if (fe) return 1;
    if (lv) return 2;
    return 0;
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    f_req_valid = 1'b1; f_req_addr = 32'h40;
    l_req_valid = 1'b1; l_req_we = 1'b0; l_req_addr = 32'h44;
    l_req_wdata = 32'h0; l_req_be = 4'h0; l_lock = 1'b0;
    f_rsp_ready = 1'b1; l_rsp_ready = 1'b1;
    #1;
    chkb("rst f_req_ready", f_req_ready, 1'b0);
    chkb("rst l_req_ready", l_req_ready, 1'b0);
    chkb("rst busy", busy, 1'b0);
    chkb("rst m_en", m_en, 1'b0);
    chkb("rst f_rsp_valid", f_rsp_valid, 1'b0);
    chkb("rst l_rsp_valid", l_rsp_valid, 1'b0);
    chk("rst m_addr", m_addr, 32'h0);
    chk("rst m_be", {28'h0, m_be}, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    f_req_valid = 1'b0; l_req_valid = 1'b0;
    rst_n = 1'b1;
    last_w = 2;
  endtask

  // Launch one request pair from IDLE and follow the transaction to completion.
  task automatic run_txn(input bit fv, input logic [31:0] fa, input bit lv, input bit lwe,
                         input logic [31:0] la, input logic [31:0] lwd, input logic [3:0] lbe,
                         input bit lock, input int eg, input string tag);
    logic [31:0] a, exp_d;
    bit rd, exp_e, to_f;
    int ek, lastk;
    @(posedge clk); #1;
    f_req_valid = fv; f_req_addr = fa;
    l_req_valid = lv; l_req_we = lwe; l_req_addr = la; l_req_wdata = lwd; l_req_be = lbe;
    l_lock = lock;
    @(negedge clk);
    chkb({tag, " f_req_ready"}, f_req_ready, eg == 1);
    chkb({tag, " l_req_ready"}, l_req_ready, eg == 2);
    @(posedge clk); #1;
    f_req_valid = 1'b0; l_req_valid = 1'b0;
    if (eg == 0) return;
    last_w = eg;
    to_f   = (eg == 1);
    a      = to_f ? fa : la;
    rd     = to_f || !lwe;
    exp_e  = rd && (a[1:0] != 2'b00);
    if (!rd)
      for (int b = 0; b < 4; b++)
        if (lbe[b]) ref_mem[a[9:2]][8*b +: 8] = lwd[8*b +: 8];
    exp_d = exp_e ? 32'h0 : ref_mem[a[9:2]];
    ek    = exp_e ? 1 : 3;
    lastk = rd ? ek + 1 : 2;
    for (int k = 1; k <= lastk; k++) begin
      @(negedge clk);
      if (k == 1) begin
        chkb({tag, " m_en"}, m_en, !exp_e);
        if (!exp_e) begin
          chkb({tag, " m_we"}, m_we, !rd);
          chk({tag, " m_addr"}, m_addr, {a[31:2], 2'b00});
          chk({tag, " m_be"}, {28'h0, m_be}, {28'h0, rd ? 4'hF : lbe});
          if (!rd) chk({tag, " m_wdata"}, m_wdata, lwd);
        end
      end
      chkb({tag, " busy"}, busy, k != lastk);
      if (rd && k <= ek) begin
        chkb({tag, " f_rsp_valid"}, f_rsp_valid, to_f && k == ek);
        chkb({tag, " l_rsp_valid"}, l_rsp_valid, !to_f && k == ek);
        if (k == ek) begin
          chk({tag, " rsp_data"}, to_f ? f_rsp_data : l_rsp_data, exp_d);
          chkb({tag, " rsp_err"}, to_f ? f_rsp_err : l_rsp_err, exp_e);
        end
      end
      if (!rd) chkb({tag, " no l_rsp"}, l_rsp_valid, 1'b0);
    end
  endtask

  typedef struct {
    bit          fv;
    logic [31:0] fa;
    bit          lv;
    bit          lwe;
    logic [31:0] la;
    logic [31:0] lwd;
    logic [3:0]  lbe;
    bit          lock;
    int          eg;
  } vec_t;

  vec_t tbl [13];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bit fv, lv, lwe, lock, seen_v, seen_en;
    logic [31:0] fa, la, lwd;
    logic [3:0] lbe;
    int eg;

    for (int i = 0; i < 256; i++) ref_mem[i] = init_val(i);
    rst3_n = 1'b0; f_req_valid3 = 1'b0; f_req_addr3 = 32'h0;

    // Reset state, then the basic aligned fetch of 0x40.
    do_reset();
    run_txn(1'b1, 32'h40, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1, "fetch40");

    // Table: round-robin from reset, writes with byte enables, lock, misalignment.
    do_reset();
    tbl[0]  = '{1'b1, 32'h40, 1'b1, 1'b0, 32'h44, 32'h0,         4'h0, 1'b0, 1};
    tbl[1]  = '{1'b1, 32'h48, 1'b1, 1'b0, 32'h4C, 32'h0,         4'h0, 1'b0, 2};
    tbl[2]  = '{1'b1, 32'h50, 1'b1, 1'b1, 32'h20, 32'hCAFE_F00D, 4'hF, 1'b0, 1};
    tbl[3]  = '{1'b1, 32'h54, 1'b1, 1'b1, 32'h20, 32'hCAFE_F00D, 4'hF, 1'b0, 2};
    tbl[4]  = '{1'b1, 32'h20, 1'b0, 1'b0, 32'h0,  32'h0,         4'h0, 1'b0, 1};
    tbl[5]  = '{1'b0, 32'h0,  1'b1, 1'b1, 32'h10, 32'hDEAD_BEEF, 4'h5, 1'b0, 2};
    tbl[6]  = '{1'b1, 32'h10, 1'b0, 1'b0, 32'h0,  32'h0,         4'h0, 1'b0, 1};
    tbl[7]  = '{1'b1, 32'h40, 1'b1, 1'b0, 32'h41, 32'h0,         4'h0, 1'b1, 2};
    tbl[8]  = '{1'b1, 32'h40, 1'b0, 1'b0, 32'h0,  32'h0,         4'h0, 1'b1, 0};
    tbl[9]  = '{1'b0, 32'h0,  1'b1, 1'b1, 32'h24, 32'h1234_5678, 4'h0, 1'b0, 2};
    tbl[10] = '{1'b1, 32'h24, 1'b0, 1'b0, 32'h0,  32'h0,         4'h0, 1'b0, 1};
    tbl[11] = '{1'b1, 32'h42, 1'b1, 1'b0, 32'h08, 32'h0,         4'h0, 1'b0, 2};
    tbl[12] = '{1'b1, 32'h42, 1'b0, 1'b0, 32'h0,  32'h0,         4'h0, 1'b0, 1};
    for (int i = 0; i < 13; i++)
      run_txn(tbl[i].fv, tbl[i].fa, tbl[i].lv, tbl[i].lwe, tbl[i].la, tbl[i].lwd,
              tbl[i].lbe, tbl[i].lock, tbl[i].eg, $sformatf("tbl%0d", i));
    chk("merged word 0x10", ref_mem[4], 32'h11AD_33EF);

    // Misaligned fetch held without f_rsp_ready.
    @(posedge clk); #1;
    f_rsp_ready = 1'b0; f_req_valid = 1'b1; f_req_addr = 32'h42; l_req_valid = 1'b0; l_lock = 1'b0;
    @(negedge clk);
    chkb("hold f_req_ready", f_req_ready, 1'b1);
    @(posedge clk); #1;
    f_req_valid = 1'b0; last_w = 1;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      chkb("hold m_en", m_en, 1'b0);
      chkb("hold f_rsp_valid", f_rsp_valid, 1'b1);
      chkb("hold f_rsp_err", f_rsp_err, 1'b1);
      chk("hold f_rsp_data", f_rsp_data, 32'h0);
      chkb("hold busy", busy, 1'b1);
    end
    @(posedge clk); #1;
    f_rsp_ready = 1'b1;
    @(negedge clk);
    chkb("hold handshake valid", f_rsp_valid, 1'b1);
    @(negedge clk);
    chkb("hold released busy", busy, 1'b0);

    // Lock: fetch starves across ten loader reads, then goes as soon as unlocked.
    @(posedge clk); #1;
    l_lock = 1'b1; f_req_valid = 1'b1; f_req_addr = 32'h40;
    for (int i = 0; i < 10; i++) begin
      l_req_valid = 1'b1; l_req_we = 1'b0; l_req_addr = 32'(i * 4);
      @(negedge clk);
      chkb("lock f_req_ready", f_req_ready, 1'b0);
      chkb("lock l_req_ready", l_req_ready, 1'b1);
      @(posedge clk); #1;
      l_req_valid = 1'b0;
      for (int k = 1; k <= 4; k++) begin
        @(negedge clk);
        chkb("lock f_req_ready wait", f_req_ready, 1'b0);
        if (k == 3) begin
          chkb("lock l_rsp_valid", l_rsp_valid, 1'b1);
          chk("lock l_rsp_data", l_rsp_data, ref_mem[i]);
        end
      end
      @(posedge clk); #1;
    end
    last_w = 2;
    l_lock = 1'b0;
    @(negedge clk);
    chkb("unlock f_req_ready", f_req_ready, 1'b1);
    @(posedge clk); #1;
    f_req_valid = 1'b0; last_w = 1;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      if (k == 3) begin
        chkb("unlock f_rsp_valid", f_rsp_valid, 1'b1);
        chk("unlock f_rsp_data", f_rsp_data, ref_mem[16]);
      end
      if (k == 4) chkb("unlock idle", busy, 1'b0);
    end

    // Random traffic against the reference model.
    for (int i = 0; i < 150; i++) begin
      fv   = 1'($urandom_range(0, 1));
      lv   = 1'($urandom_range(0, 1));
      lwe  = 1'($urandom_range(0, 1));
      lock = ($urandom_range(0, 3) == 0);
      fa   = {22'h0, 8'($urandom_range(0, 255)), 2'b00};
      la   = {22'h0, 8'($urandom_range(0, 255)), 2'b00};
      if ($urandom_range(0, 4) == 0) fa[1:0] = 2'($urandom_range(1, 3));
      if ($urandom_range(0, 4) == 0) la[1:0] = 2'($urandom_range(1, 3));
      lwd  = $urandom;
      lbe  = 4'($urandom_range(0, 15));
      eg   = pick(fv, lv, lock, last_w);
      run_txn(fv, fa, lv, lwe, la, lwd, lbe, lock, eg, $sformatf("rnd%0d", i));
    end

    // MEM_LAT=3 instance: reset during WAIT drops the fetch; next fetch is exact.
    @(posedge clk); #1;
    rst3_n = 1'b1;
    @(posedge clk); #1;
    f_req_valid3 = 1'b1; f_req_addr3 = 32'h40;
    @(negedge clk);
    chkb("l3 f_req_ready", f_req_ready3, 1'b1);
    @(posedge clk); #1;
    f_req_valid3 = 1'b0;
    @(negedge clk);
    chkb("l3 cmd m_en", m_en3, 1'b1);
    @(posedge clk); #1;
    @(negedge clk);
    chkb("l3 wait busy", busy3, 1'b1);
    chkb("l3 wait m_en", m_en3, 1'b0);
    #1;
    f_req_valid3 = 1'b1;
    rst3_n = 1'b0;
    #1;
    chkb("l3 rst busy", busy3, 1'b0);
    chkb("l3 rst m_en", m_en3, 1'b0);
    chk("l3 rst m_addr", m_addr3, 32'h0);
    chk("l3 rst m_be", {28'h0, m_be3}, 32'h0);
    chkb("l3 rst f_rsp_valid", f_rsp_valid3, 1'b0);
    chkb("l3 rst f_req_ready", f_req_ready3, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    f_req_valid3 = 1'b0;
    rst3_n = 1'b1;
    seen_v = 1'b0; seen_en = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      seen_v  = seen_v | f_rsp_valid3;
      seen_en = seen_en | m_en3;
    end
    chkb("l3 no rsp after reset", seen_v, 1'b0);
    chkb("l3 no m_en after reset", seen_en, 1'b0);
    @(posedge clk); #1;
    f_req_valid3 = 1'b1; f_req_addr3 = 32'h40;
    @(negedge clk);
    chkb("l3 refetch ready", f_req_ready3, 1'b1);
    @(posedge clk); #1;
    f_req_valid3 = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (k <= 5) chkb($sformatf("l3 f_rsp_valid k%0d", k), f_rsp_valid3, k == 5);
      if (k == 5) begin
        chk("l3 f_rsp_data", f_rsp_data3, 32'h0000_0013);
        chkb("l3 f_rsp_err", f_rsp_err3, 1'b0);
      end
      if (k == 6) chkb("l3 idle", busy3, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
